// File: rtl/bounding_box_iterator.sv
// bounding_box_iterator: walks an inclusive signed bounding box in row-major
// order (x fastest), one coordinate per accepted enable.
// Optional: define BBOX_PIXEL_COUNT_EN to add the o_count pixel counter.
module bounding_box_iterator #(
    parameter int CW = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    input  logic                 i_write,
    input  logic signed [CW-1:0] i_bbx0,
    input  logic signed [CW-1:0] i_bbx1,
    input  logic signed [CW-1:0] i_bby0,
    input  logic signed [CW-1:0] i_bby1,
    output logic                 o_done,
`ifdef BBOX_PIXEL_COUNT_EN
    output logic [31:0]          o_count,
`endif
    output logic signed [CW-1:0] o_x,
    output logic signed [CW-1:0] o_y
);

    typedef enum logic {S_IDLE, S_ITER} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic signed [CW-1:0] r_x0, r_x1, r_y1;
    logic signed [CW-1:0] r_x, r_y;
    logic               w_empty;
    logic               w_adv;
    logic               w_x_more;
    logic               w_y_more;

    localparam logic signed [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    assign w_empty  = (i_bbx0 > i_bbx1) || (i_bby0 > i_bby1);
    assign w_adv    = i_enable && !i_write && (r_state == S_ITER);
    assign w_x_more = (r_x < r_x1);
    assign w_y_more = (r_y < r_y1);

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next_state;
    end

    // Next state: a write always restarts; last-pixel enable finishes.
    always_comb begin
        w_next_state = r_state;
        if (i_write)
            w_next_state = w_empty ? S_IDLE : S_ITER;
        else if (w_adv && !w_x_more && !w_y_more)
            w_next_state = S_IDLE;
    end

    // Bounds latch and coordinate stepping; y0 is only needed at load time.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_x0 <= '0;
            r_x1 <= '0;
            r_y1 <= '0;
            r_x  <= '0;
            r_y  <= '0;
        end else if (i_write) begin
            r_x0 <= i_bbx0;
            r_x1 <= i_bbx1;
            r_y1 <= i_bby1;
            r_x  <= i_bbx0;
            r_y  <= i_bby0;
        end else if (w_adv) begin
            if (w_x_more) begin
                r_x <= r_x + ONE;
            end else if (w_y_more) begin
                r_x <= r_x0;
                r_y <= r_y + ONE;
            end
        end
    end

`ifdef BBOX_PIXEL_COUNT_EN
    logic [31:0] r_count;

    // Pixels consumed since the last load, including the final one.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)   r_count <= '0;
        else if (i_write) r_count <= '0;
        else if (w_adv)   r_count <= r_count + 32'd1;
    end

    assign o_count = r_count;
`endif

    assign o_done = (r_state == S_IDLE);
    assign o_x    = r_x;
    assign o_y    = r_y;

endmodule

// File: tb/tb_bounding_box_iterator.sv
// Directed bench for bounding_box_iterator with hand-computed expectations.
module tb_bounding_box_iterator;

    localparam int CW = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic                 wr;
    logic signed [CW-1:0] bx0, bx1, by0, by1;
    logic                 done;
    logic signed [CW-1:0] x, y;
`ifdef BBOX_PIXEL_COUNT_EN
    logic [31:0]          count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bounding_box_iterator #(.CW(CW)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_enable  (en),
        .i_write   (wr),
        .i_bbx0    (bx0),
        .i_bbx1    (bx1),
        .i_bby0    (by0),
        .i_bby1    (by1),
        .o_done    (done),
`ifdef BBOX_PIXEL_COUNT_EN
        .o_count   (count),
`endif
        .o_x       (x),
        .o_y       (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey,
                           input int ed);
        chk({tag, ".x"}, x, ex);
        chk({tag, ".y"}, y, ey);
        chk({tag, ".done"}, {31'd0, done}, ed);
    endtask

    // One clock edge; sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ax0, input int ax1, input int ay0,
                        input int ay1);
        bx0 = CW'(ax0); bx1 = CW'(ax1);
        by0 = CW'(ay0); by1 = CW'(ay1);
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; wr = 1'b0;
        bx0 = '0; bx1 = '0; by0 = '0; by1 = '0;
        #2 rst_n = 1'b0;
        #1;
        chk_pos("reset", 0, 0, 1);
`ifdef BBOX_PIXEL_COUNT_EN
        chk("reset.count", count, 0);
`endif
        #9 rst_n = 1'b1;
        tick();
        chk_pos("post_reset", 0, 0, 1);

        // Box x 2..4, y 5..6: six pixels.
        load(2, 4, 5, 6);
        chk_pos("b1.load", 2, 5, 0);
        en = 1'b1;
        tick(); chk_pos("b1.e1", 3, 5, 0);
        tick(); chk_pos("b1.e2", 4, 5, 0);
        tick(); chk_pos("b1.e3", 2, 6, 0);
        tick(); chk_pos("b1.e4", 3, 6, 0);
        tick(); chk_pos("b1.e5", 4, 6, 0);
        tick(); chk_pos("b1.e6", 4, 6, 1);
`ifdef BBOX_PIXEL_COUNT_EN
        chk("b1.count", count, 6);
`endif
        tick(); chk_pos("b1.hold", 4, 6, 1);
`ifdef BBOX_PIXEL_COUNT_EN
        chk("b1.count_hold", count, 6);
`endif
        en = 1'b0;

        // Negative bounds x -1..0, y -1.
        load(-1, 0, -1, -1);
        chk_pos("b2.load", -1, -1, 0);
        en = 1'b1;
        tick(); chk_pos("b2.e1", 0, -1, 0);
        tick(); chk_pos("b2.e2", 0, -1, 1);
        en = 1'b0;

        // Empty box x 5..3.
        load(5, 3, 7, 9);
        chk_pos("empty.load", 5, 7, 1);
        en = 1'b1;
        tick(); tick();
        chk_pos("empty.en", 5, 7, 1);
`ifdef BBOX_PIXEL_COUNT_EN
        chk("empty.count", count, 0);
`endif
        en = 1'b0;

        // Write and enable together: write wins.
        en = 1'b1;
        load(0, 1, 0, 1);
        chk_pos("wwin.load", 0, 0, 0);
`ifdef BBOX_PIXEL_COUNT_EN
        chk("wwin.count", count, 0);
`endif
        tick(); chk_pos("wwin.e1", 1, 0, 0);
        tick(); chk_pos("wwin.e2", 0, 1, 0);
        en = 1'b0;
        // Restart mid-iteration with a single-pixel box.
        load(10, 10, 20, 20);
        chk_pos("single.load", 10, 20, 0);
`ifdef BBOX_PIXEL_COUNT_EN
        chk("single.count0", count, 0);
`endif
        en = 1'b1;
        tick(); chk_pos("single.e1", 10, 20, 1);
`ifdef BBOX_PIXEL_COUNT_EN
        chk("single.count1", count, 1);
`endif
        en = 1'b0;

        // Enables separated by idle gaps, box x 0..1, y 0.
        load(0, 1, 0, 0);
        chk_pos("gap.load", 0, 0, 0);
        en = 1'b1; tick(); en = 1'b0;
        chk_pos("gap.e1", 1, 0, 0);
        tick(); tick(); tick();
        chk_pos("gap.idle", 1, 0, 0);
        en = 1'b1; tick(); en = 1'b0;
        chk_pos("gap.e2", 1, 0, 1);
`ifdef BBOX_PIXEL_COUNT_EN
        chk("gap.count", count, 2);
`endif

        // Asynchronous reset in the middle of an iteration.
        load(0, 3, 0, 0);
        en = 1'b1; tick(); en = 1'b0;
        chk_pos("mid.e1", 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_pos("mid.reset", 0, 0, 1);
`ifdef BBOX_PIXEL_COUNT_EN
        chk("mid.count", count, 0);
`endif
        #3 rst_n = 1'b1;
        tick();
        chk_pos("mid.after", 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bounding_box_iterator.md
Name: bounding_box_iterator

Overview:
- Generates raster pixel coordinates covering an inclusive, axis-aligned bounding box, in row-major order (x fastest).
- Feeds the triangle raster engine: the engine's control FSM loads the clipped box, then requests one coordinate per step for the edge-function evaluator.
- Pure sequencer; no arithmetic beyond increment and compare.

Parameters:
- CW, 16, coordinate width in bits (signed two's complement).

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_enable  input  1  advance to next coordinate this cycle.
- i_write  input  1  load a new box from i_bbx0..i_bby1.
- i_bbx0  input  CW  signed x minimum (inclusive).
- i_bbx1  input  CW  signed x maximum (inclusive).
- i_bby0  input  CW  signed y minimum (inclusive).
- i_bby1  input  CW  signed y maximum (inclusive).
- o_done  output  1  high when no further coordinates remain, or no box is loaded.
- o_x  output  CW  current x coordinate (registered).
- o_y  output  CW  current y coordinate (registered).
- o_count  output  32  pixels consumed; present only with BBOX_PIXEL_COUNT_EN.

Behaviour:
- Reset (async assert, sync release): o_x=0, o_y=0, o_done=1, internal bounds=0, o_count=0.
- Write:
  - i_write=1 latches all four bounds.
  - Next cycle: o_x=i_bbx0, o_y=i_bby0.
  - o_done=0 unless the box is empty (i_bbx0>i_bbx1 or i_bby0>i_bby1, signed compare), in which case o_done=1.
- Advance: i_enable=1 with o_done=0 and i_write=0, next edge:
  - if o_x<x1: o_x<=o_x+1.
  - else if o_y<y1: o_x<=x0, o_y<=o_y+1.
  - else (at (x1,y1)): o_done<=1, o_x/o_y hold (x1,y1).
- Latency: the coordinate presented after a write is the first pixel. Each accepted enable exposes the next pixel one cycle later. A WxH box needs exactly W*H enables to reach o_done=1.
- i_enable while o_done=1: ignored; outputs hold.
- i_write and i_enable in the same cycle: write wins, enable discarded.
- i_write while iterating: restarts immediately with the new box, no drain.
- Reset asserted mid-iteration: outputs go to reset values at once; o_done=1.
- Single-pixel box (x0=x1, y0=y1): o_done=0 after write; one enable sets o_done=1.
- Comparisons are signed; negative bounds are legal. No saturation is needed because o_x never exceeds x1.
- Two states, IDLE (o_done=1) and ITER (o_done=0):
  - IDLE to ITER on a non-empty write.
  - ITER to IDLE on an enable at the last pixel.
  - ITER to ITER on any write (back to IDLE if that box is empty).

Optional Feature:
- BBOX_PIXEL_COUNT_EN defined:
  - adds o_count (32-bit, unsigned), reset 0 and cleared to 0 on every i_write;
  - increments on each accepted advance, including the final enable that sets o_done;
  - equals W*H when o_done rises after a non-empty box.
- Undefined: o_count port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert i_reset_n=0 mid-cycle -> o_done=1, o_x=0, o_y=0 immediately without a clock.
- Write box x 2..4, y 5..6, then 6 enables -> sequence (2,5)(3,5)(4,5)(2,6)(3,6)(4,6). o_done rises on the 6th enable and o_x/o_y hold (4,6). With feature enabled, o_count=6.
- Write box x -1..0, y -1..-1, then 2 enables -> (-1,-1),(0,-1), then o_done=1.
- Empty box (x0=5, x1=3): after write o_done=1; enables leave o_x=5, o_y unchanged.
- Write box x 0..1, y 0..1 and pulse i_enable in the same cycle -> o_x=0, o_y=0 (write wins). Advance twice -> (0,1). Then rewrite box x 10..10, y 20..20 -> o_x=10, o_y=20, o_done=0; one enable -> o_done=1.
- Enables with gaps (i_enable low for 3 cycles between steps) on box x 0..1, y 0..0 -> coordinates change only on enabled edges; o_done after exactly 2 enables.
